// File: rtl/receptor_32_if.sv
// Byte-in / word-out bundle between the UART byte receiver, the word
// assembler and the word consumer.
interface receptor_32_if #(
   parameter int NB_DATA    = 32,
   parameter int NB_TX_DATA = 8
);
   logic [NB_TX_DATA-1:0] i_rx_data;
   logic                  i_rx_valid;
   logic                  i_tick;
   logic [NB_DATA-1:0]    o_data;
   logic                  o_valid;
   logic                  o_busy;
   logic                  o_timeout;

   modport slave (
      input  i_rx_data, i_rx_valid, i_tick,
      output o_data, o_valid, o_busy, o_timeout
   );

   modport master (
      output i_rx_data, i_rx_valid, i_tick,
      input  o_data, o_valid, o_busy, o_timeout
   );
endinterface

// File: rtl/receptor_32.sv
// Receive-side word assembler: packs little-endian bytes into one word and
// drops partial words after an inter-byte timeout measured in baud ticks.
module receptor_32 #(
   parameter int NB_DATA       = 32,
   parameter int NB_TX_DATA    = 8,
   parameter int NB_COUNT      = 3,
   parameter int NB_STATES     = 3,
   parameter int NB_TIMER      = 10,
   parameter int TIMEOUT_TICKS = 480
) (
   input  logic          i_clk,
   input  logic          i_reset,
   receptor_32_if.slave  bus
);
   localparam int NB_WORDS = NB_DATA / NB_TX_DATA;

   typedef enum logic [NB_STATES-1:0] {
      SECURE = 3'b001,
      IDLE   = 3'b010,
      RECV   = 3'b100
   } state_e;

   state_e                state_q,   state_d;
   logic [NB_DATA-1:0]    shreg_q,   shreg_d;
   logic [NB_COUNT-1:0]   count_q,   count_d;
   logic [NB_TIMER-1:0]   timer_q,   timer_d;
   logic [NB_DATA-1:0]    data_q,    data_d;
   logic                  valid_q,   valid_d;
   logic                  timeout_q, timeout_d;

   logic [NB_DATA-1:0]    shifted_s;
   logic                  last_byte_s;
   logic                  timer_full_s;

   assign shifted_s    = {bus.i_rx_data, shreg_q[NB_DATA-1:NB_TX_DATA]};
   assign last_byte_s  = (count_q == NB_COUNT'(NB_WORDS - 1));
   assign timer_full_s = (timer_q == NB_TIMER'(TIMEOUT_TICKS));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= IDLE;
         shreg_q   <= {NB_DATA{1'b0}};
         count_q   <= {NB_COUNT{1'b0}};
         timer_q   <= {NB_TIMER{1'b0}};
         data_q    <= {NB_DATA{1'b0}};
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         count_q   <= count_d;
         timer_q   <= timer_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      count_d   = count_q;
      timer_d   = timer_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            timer_d = {NB_TIMER{1'b0}};
            if (bus.i_rx_valid) begin
               // count_q is 0 here, so last_byte_s only fires for one-byte words
               if (last_byte_s) begin
                  data_d  = shifted_s;
                  valid_d = 1'b1;
                  shreg_d = {NB_DATA{1'b0}};
                  count_d = {NB_COUNT{1'b0}};
               end else begin
                  shreg_d = shifted_s;
                  count_d = NB_COUNT'(1);
                  state_d = RECV;
               end
            end else begin
               state_d = IDLE;
            end
         end

         RECV: begin
            if (bus.i_rx_valid) begin
               timer_d = {NB_TIMER{1'b0}};
               if (last_byte_s) begin
                  data_d  = shifted_s;
                  valid_d = 1'b1;
                  shreg_d = {NB_DATA{1'b0}};
                  count_d = {NB_COUNT{1'b0}};
                  state_d = IDLE;
               end else begin
                  shreg_d = shifted_s;
                  count_d = count_q + NB_COUNT'(1);
               end
            end else if (timer_full_s) begin
               timeout_d = 1'b1;
               shreg_d   = {NB_DATA{1'b0}};
               count_d   = {NB_COUNT{1'b0}};
               timer_d   = {NB_TIMER{1'b0}};
               state_d   = IDLE;
            end else if (bus.i_tick) begin
               timer_d = timer_q + NB_TIMER'(1);
            end else begin
               timer_d = timer_q;
            end
         end

         SECURE: begin
            shreg_d = {NB_DATA{1'b0}};
            count_d = {NB_COUNT{1'b0}};
            timer_d = {NB_TIMER{1'b0}};
            state_d = IDLE;
         end

         default: begin
            shreg_d = {NB_DATA{1'b0}};
            count_d = {NB_COUNT{1'b0}};
            timer_d = {NB_TIMER{1'b0}};
            state_d = SECURE;
         end
      endcase
   end

   assign bus.o_data    = data_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_timeout = timeout_q;
   assign bus.o_busy    = (state_q == RECV);
endmodule
